itable_sequencer: RTL and testbench

- Drives the instruction decoder tree.
- Holds the current opcode (ITABLE) and the T-state counter (XPT), each with its complement.
- Gates the decoder with `enable`, and tracks the machine-cycle and index-prefix modes.
- Consumes the sequencing pulses the decoder emits (PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, P2_Set_CMR, P2_Set_ILDlIXtdln_1, P2_Set_ILDlIYtdln_1) and closes the fetch/decode/execute loop.

---
 rtl/norz_seq_pkg.sv | 15 +
 rtl/xpt_counter.sv | 35 +++
 rtl/itable_sequencer.sv | 135 +++++++++++++
 tb/tb_itable_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norz_seq_pkg.sv
// Shared types and constants for the instruction-table sequencer.
// The state enum, T-state counter limits and ITABLE reset value live here.
package norz_seq_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        ILD   = 2'd2
    } seq_state_t;

    localparam int               XPT_W      = 4;
    localparam logic [XPT_W-1:0] XPT_MAX    = 4'd15;
    localparam logic [7:0]       ITABLE_RST = 8'h00;

endpackage

// File: rtl/xpt_counter.sv
// Saturating T-state counter with clear/increment/hold controls.
// An increment attempted at MAX leaves the count alone and latches a sticky overflow.
module xpt_counter
    import norz_seq_pkg::*;
#(
    parameter int         W   = XPT_W,
    parameter logic [W-1:0] MAX = XPT_MAX
) (
    input  logic         clock,
    input  logic         notReset,
    input  logic         hold,
    input  logic         clear,
    input  logic         incr,
    output logic [W-1:0] count,
    output logic         overflow
);

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (!hold) begin
            if (clear) begin
                count <= '0;
            end else if (incr) begin
                if (count == MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/itable_sequencer.sv
// Fetch/decode/execute sequencer: holds the opcode latch and T-state counter,
// gates the decoder tree and reacts to the decoder's sequencing pulses.
module itable_sequencer
    import norz_seq_pkg::*;
(
    input  logic             clock,
    input  logic             notReset,
    input  logic             notWait,
    input  logic             op_valid,
    input  logic [7:0]       Dt_in,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Set_CM1,
    input  logic             P2_Reset_ITABLE,
    input  logic             P2_Set_CMR,
    input  logic             P2_Set_ILDlIXtdln_1,
    input  logic             P2_Set_ILDlIYtdln_1,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic [7:0]       ITABLE,
    output logic [7:0]       notITABLE,
    output logic             enable,
    output logic             CM1,
    output logic             fetch_req,
    output logic             ix_mode,
    output logic             iy_mode,
    output logic             ild_active,
    output logic             seq_error
);

    seq_state_t state;
    seq_state_t state_next;
    logic [7:0] itable_next;
    logic       ix_next;
    logic       iy_next;
    logic       xpt_clear;
    logic       xpt_incr;

    // notWait low freezes everything, so the counter shares the same hold.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state   <= FETCH;
            ITABLE  <= ITABLE_RST;
            ix_mode <= 1'b0;
            iy_mode <= 1'b0;
        end else if (notWait) begin
            state   <= state_next;
            ITABLE  <= itable_next;
            ix_mode <= ix_next;
            iy_mode <= iy_next;
        end
    end

    always_comb begin
        state_next  = state;
        itable_next = ITABLE;
        ix_next     = ix_mode;
        iy_next     = iy_mode;
        xpt_clear   = 1'b0;
        xpt_incr    = 1'b0;
        case (state)
            FETCH: begin
                if (op_valid) begin
                    state_next  = EXEC;
                    itable_next = Dt_in;
                    xpt_clear   = 1'b1;
                end
            end
            EXEC: begin
                if (P2_Reset_ITABLE) begin
                    itable_next = ITABLE_RST;
                end
                if (P2_Set_CM1) begin
                    state_next = FETCH;
                    xpt_clear  = 1'b1;
                    ix_next    = 1'b0;
                    iy_next    = 1'b0;
                end else if (P2_Set_CMR) begin
                    state_next = FETCH;
                    xpt_clear  = 1'b1;
                end else if (P2_Set_ILDlIXtdln_1) begin
                    state_next = ILD;
                    xpt_clear  = 1'b1;
                    ix_next    = 1'b1;
                    iy_next    = 1'b0;
                end else if (P2_Set_ILDlIYtdln_1) begin
                    state_next = ILD;
                    xpt_clear  = 1'b1;
                    ix_next    = 1'b0;
                    iy_next    = 1'b1;
                end else if (PR_Reset_XPT) begin
                    xpt_clear = 1'b1;
                end else begin
                    xpt_incr = 1'b1;
                end
            end
            ILD: begin
                // The displacement byte feeds the datapath; ITABLE keeps the opcode.
                if (op_valid) begin
                    state_next = EXEC;
                    xpt_clear  = 1'b1;
                end else begin
                    xpt_incr = 1'b1;
                end
            end
            default: begin
                state_next = FETCH;
                xpt_clear  = 1'b1;
            end
        endcase
    end

    xpt_counter #(
        .W   (XPT_W),
        .MAX (XPT_MAX)
    ) u_xpt (
        .clock    (clock),
        .notReset (notReset),
        .hold     (!notWait),
        .clear    (xpt_clear),
        .incr     (xpt_incr),
        .count    (XPT),
        .overflow (seq_error)
    );

    always_comb begin
        CM1        = (state == FETCH);
        fetch_req  = (state == FETCH) || (state == ILD);
        enable     = (state == EXEC) || (state == ILD);
        ild_active = (state == ILD);
    end

    assign notXPT    = ~XPT;
    assign notITABLE = ~ITABLE;

endmodule

// File: tb/tb_itable_sequencer.sv
// Self-checking bench for itable_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_itable_sequencer;

    localparam logic [5:0] P_RXPT = 6'b000001;
    localparam logic [5:0] P_CM1  = 6'b000010;
    localparam logic [5:0] P_RIT  = 6'b000100;
    localparam logic [5:0] P_CMR  = 6'b001000;
    localparam logic [5:0] P_IX   = 6'b010000;
    localparam logic [5:0] P_IY   = 6'b100000;

    localparam int M_FETCH = 0;
    localparam int M_EXEC  = 1;
    localparam int M_ILD   = 2;

    logic       clock;
    logic       notReset;
    logic       notWait;
    logic       op_valid;
    logic [7:0] Dt_in;
    logic       PR_Reset_XPT;
    logic       P2_Set_CM1;
    logic       P2_Reset_ITABLE;
    logic       P2_Set_CMR;
    logic       P2_Set_ILDlIXtdln_1;
    logic       P2_Set_ILDlIYtdln_1;
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic [7:0] ITABLE;
    logic [7:0] notITABLE;
    logic       enable;
    logic       CM1;
    logic       fetch_req;
    logic       ix_mode;
    logic       iy_mode;
    logic       ild_active;
    logic       seq_error;

    int n_vectors;
    int n_miscompares;

    // Behavioural model: phase of the instruction, counter value and mode flags.
    int m_state;
    int m_xpt;
    int m_itable;
    int m_ix;
    int m_iy;
    int m_err;

    itable_sequencer dut (
        .clock               (clock),
        .notReset            (notReset),
        .notWait             (notWait),
        .op_valid            (op_valid),
        .Dt_in               (Dt_in),
        .PR_Reset_XPT        (PR_Reset_XPT),
        .P2_Set_CM1          (P2_Set_CM1),
        .P2_Reset_ITABLE     (P2_Reset_ITABLE),
        .P2_Set_CMR          (P2_Set_CMR),
        .P2_Set_ILDlIXtdln_1 (P2_Set_ILDlIXtdln_1),
        .P2_Set_ILDlIYtdln_1 (P2_Set_ILDlIYtdln_1),
        .XPT                 (XPT),
        .notXPT              (notXPT),
        .ITABLE              (ITABLE),
        .notITABLE           (notITABLE),
        .enable              (enable),
        .CM1                 (CM1),
        .fetch_req           (fetch_req),
        .ix_mode             (ix_mode),
        .iy_mode             (iy_mode),
        .ild_active          (ild_active),
        .seq_error           (seq_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare(input string name, input int act, input int exp);
        n_vectors++;
        if (act != exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_state  = M_FETCH;
        m_xpt    = 0;
        m_itable = 0;
        m_ix     = 0;
        m_iy     = 0;
        m_err    = 0;
    endtask

    task automatic modelBump();
        if (m_xpt == 15) m_err = 1;
        else m_xpt = m_xpt + 1;
    endtask

    task automatic modelStep();
        if (!notReset) begin
            modelReset();
        end else if (notWait) begin
            case (m_state)
                M_FETCH: begin
                    if (op_valid) begin
                        m_itable = int'(Dt_in);
                        m_xpt    = 0;
                        m_state  = M_EXEC;
                    end
                end
                M_EXEC: begin
                    if (P2_Reset_ITABLE) m_itable = 0;
                    if (P2_Set_CM1) begin
                        m_state = M_FETCH; m_xpt = 0; m_ix = 0; m_iy = 0;
                    end else if (P2_Set_CMR) begin
                        m_state = M_FETCH; m_xpt = 0;
                    end else if (P2_Set_ILDlIXtdln_1) begin
                        m_state = M_ILD; m_xpt = 0; m_ix = 1; m_iy = 0;
                    end else if (P2_Set_ILDlIYtdln_1) begin
                        m_state = M_ILD; m_xpt = 0; m_ix = 0; m_iy = 1;
                    end else if (PR_Reset_XPT) begin
                        m_xpt = 0;
                    end else begin
                        modelBump();
                    end
                end
                default: begin
                    if (op_valid) begin
                        m_state = M_EXEC; m_xpt = 0;
                    end else begin
                        modelBump();
                    end
                end
            endcase
        end
    endtask

    task automatic checkOutput();
        compare("XPT", int'(XPT), m_xpt);
        compare("notXPT", int'(notXPT), (~m_xpt) & 32'hF);
        compare("ITABLE", int'(ITABLE), m_itable);
        compare("notITABLE", int'(notITABLE), (~m_itable) & 32'hFF);
        compare("CM1", int'(CM1), int'(m_state == M_FETCH));
        compare("fetch_req", int'(fetch_req), int'(m_state != M_EXEC));
        compare("enable", int'(enable), int'(m_state != M_FETCH));
        compare("ild_active", int'(ild_active), int'(m_state == M_ILD));
        compare("ix_mode", int'(ix_mode), m_ix);
        compare("iy_mode", int'(iy_mode), m_iy);
        compare("seq_error", int'(seq_error), m_err);
    endtask

    task automatic applyStimulus(input logic ov, input logic [7:0] dt,
                                 input logic [5:0] p, input logic nw);
        op_valid            = ov;
        Dt_in               = dt;
        PR_Reset_XPT        = p[0];
        P2_Set_CM1          = p[1];
        P2_Reset_ITABLE     = p[2];
        P2_Set_CMR          = p[3];
        P2_Set_ILDlIXtdln_1 = p[4];
        P2_Set_ILDlIYtdln_1 = p[5];
        notWait             = nw;
        @(posedge clock);
        modelStep();
        @(negedge clock);
        checkOutput();
    endtask

    // Pulses reset between edges; the release lands before the next rising edge.
    task automatic doReset();
        notReset = 1'b0;
        modelReset();
        #2;
        notReset = 1'b1;
    endtask

    initial begin
        logic [5:0] p;
        logic       ov;
        logic       nw;
        logic [7:0] dt;
        logic       quiet;

        n_vectors     = 0;
        n_miscompares = 0;
        notReset      = 1'b0;
        applyStimulusIdleInputs();
        modelReset();

        #7;
        compare("rst XPT", int'(XPT), 0);
        compare("rst notXPT", int'(notXPT), 15);
        compare("rst ITABLE", int'(ITABLE), 0);
        compare("rst notITABLE", int'(notITABLE), 8'hFF);
        compare("rst CM1", int'(CM1), 1);
        compare("rst fetch_req", int'(fetch_req), 1);
        compare("rst enable", int'(enable), 0);
        compare("rst ild_active", int'(ild_active), 0);
        compare("rst seq_error", int'(seq_error), 0);
        #1;
        notReset = 1'b1;
        @(negedge clock);

        applyStimulus(1'b1, 8'h80, 6'd0, 1'b1);
        compare("load ITABLE", int'(ITABLE), 8'h80);
        compare("load notITABLE", int'(notITABLE), 8'h7F);
        compare("load enable", int'(enable), 1);
        compare("load CM1", int'(CM1), 0);
        compare("load XPT", int'(XPT), 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 8'h00, 6'd0, 1'b1);
            compare("count XPT", int'(XPT), k);
        end
        applyStimulus(1'b0, 8'h00, P_CM1 | P_RIT, 1'b1);
        compare("cm1 CM1", int'(CM1), 1);
        compare("cm1 XPT", int'(XPT), 0);
        compare("cm1 ITABLE", int'(ITABLE), 0);

        applyStimulus(1'b1, 8'hDD, 6'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, P_IX, 1'b1);
        compare("ildx ix_mode", int'(ix_mode), 1);
        compare("ildx ild_active", int'(ild_active), 1);
        compare("ildx fetch_req", int'(fetch_req), 1);
        applyStimulus(1'b1, 8'h05, 6'd0, 1'b1);
        compare("disp ITABLE", int'(ITABLE), 8'hDD);
        compare("disp XPT", int'(XPT), 0);
        compare("disp ix_mode", int'(ix_mode), 1);
        compare("disp ild_active", int'(ild_active), 0);
        applyStimulus(1'b0, 8'h00, P_CM1, 1'b1);
        compare("end ix_mode", int'(ix_mode), 0);

        applyStimulus(1'b1, 8'h3E, 6'd0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 8'h00, 6'd0, 1'b1);
            compare("sat XPT", int'(XPT), (k < 15) ? k : 15);
            compare("sat seq_error", int'(seq_error), (k >= 16) ? 1 : 0);
        end
        doReset();
        #1;
        compare("clr seq_error", int'(seq_error), 0);

        applyStimulus(1'b1, 8'h21, 6'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 6'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 6'd0, 1'b1);
        compare("wait pre XPT", int'(XPT), 2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 8'h00, P_RXPT, 1'b0);
            compare("wait XPT", int'(XPT), 2);
        end
        applyStimulus(1'b0, 8'h00, 6'd0, 1'b1);
        compare("wait post XPT", int'(XPT), 3);

        applyStimulus(1'b0, 8'h00, P_CM1, 1'b1);
        applyStimulus(1'b1, 8'hDD, 6'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, P_IX, 1'b1);
        compare("ild2 ild_active", int'(ild_active), 1);
        op_valid = 1'b1;
        Dt_in    = 8'h05;
        #2;
        notReset = 1'b0;
        modelReset();
        #1;
        compare("arst CM1", int'(CM1), 1);
        compare("arst XPT", int'(XPT), 0);
        compare("arst ITABLE", int'(ITABLE), 0);
        compare("arst ix_mode", int'(ix_mode), 0);
        compare("arst fetch_req", int'(fetch_req), 1);
        compare("arst ild_active", int'(ild_active), 0);
        op_valid = 1'b0;
        #1;
        notReset = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) doReset();
            quiet = ((c % 200) < 24);
            ov    = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
            dt    = 8'($urandom);
            p     = 6'd0;
            if (!quiet) begin
                for (int b = 0; b < 6; b++) p[b] = ($urandom_range(0, 15) == 0);
            end
            if (m_state == M_ILD) p[2] = 1'b0;
            nw = ($urandom_range(0, 9) != 0);
            applyStimulus(ov, dt, p, nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    task automatic applyStimulusIdleInputs();
        notWait             = 1'b1;
        op_valid            = 1'b0;
        Dt_in               = 8'h00;
        PR_Reset_XPT        = 1'b0;
        P2_Set_CM1          = 1'b0;
        P2_Reset_ITABLE     = 1'b0;
        P2_Set_CMR          = 1'b0;
        P2_Set_ILDlIXtdln_1 = 1'b0;
        P2_Set_ILDlIYtdln_1 = 1'b0;
    endtask

endmodule
